// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, imem req/ack handshake, one-entry skid, redirect and halt
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        ill_instr,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instruction_n, instr_pc_n;
  logic        instr_valid_n;
  logic        skid_valid, skid_valid_n;
  logic [31:0] skid_data, skid_data_n, skid_pc, skid_pc_n;
  // hold keeps an already-issued request alive until its ack; its data is then dropped
  logic        hold, hold_n;
  logic [31:0] hold_addr, hold_addr_n;
  logic        ack_ok, pending;

  assign imem_req  = hold || (state == FETCH && !skid_valid);
  assign imem_addr = hold ? hold_addr : pc;
  assign halted    = (state == HALT);
  assign ack_ok    = imem_ack && imem_req;
  assign pending   = imem_req && !imem_ack;

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instruction_n = instruction;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    skid_valid_n  = skid_valid;
    skid_data_n   = skid_data;
    skid_pc_n     = skid_pc;
    hold_n        = hold;
    hold_addr_n   = hold_addr;
    if (state != HALT && redirect) begin
      instr_valid_n = 1'b0;
      instruction_n = NOP;
      skid_valid_n  = 1'b0;
      hold_n        = pending;
      hold_addr_n   = imem_addr;
      if (redirect_pc[1:0] != 2'b00) begin
        state_n = HALT;
      end else begin
        pc_n    = redirect_pc;
        state_n = pending ? DRAIN : FETCH;
      end
    end else begin
      case (state)
        BOOT: state_n = FETCH;
        DRAIN: begin
          if (ack_ok) begin
            hold_n  = 1'b0;
            state_n = FETCH;
          end
        end
        HALT: begin
          if (ack_ok) hold_n = 1'b0;
        end
        default: begin
          if (ill_instr && instr_valid && !stall) begin
            state_n       = HALT;
            instr_valid_n = 1'b0;
            instruction_n = NOP;
            skid_valid_n  = 1'b0;
            hold_n        = pending;
            hold_addr_n   = imem_addr;
          end else if (instr_valid && stall) begin
            if (ack_ok) begin
              skid_valid_n = 1'b1;
              skid_data_n  = imem_rdata;
              skid_pc_n    = pc;
              pc_n         = pc + 32'd4;
            end
          end else if (skid_valid) begin
            instruction_n = skid_data;
            instr_pc_n    = skid_pc;
            instr_valid_n = 1'b1;
            skid_valid_n  = 1'b0;
          end else if (ack_ok) begin
            instruction_n = imem_rdata;
            instr_pc_n    = pc;
            instr_valid_n = 1'b1;
            pc_n          = pc + 32'd4;
          end else begin
            instr_valid_n = 1'b0;
            instruction_n = NOP;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instruction <= NOP;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      skid_valid  <= 1'b0;
      skid_data   <= NOP;
      skid_pc     <= RESET_PC;
      hold        <= 1'b0;
      hold_addr   <= RESET_PC;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instruction <= instruction_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      skid_valid  <= skid_valid_n;
      skid_data   <= skid_data_n;
      skid_pc     <= skid_pc_n;
      hold        <= hold_n;
      hold_addr   <= hold_addr_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch
module tb_instr_fetch;
  localparam logic [31:0] K   = 32'h0050_0093;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ack = 1'b0, stall = 1'b0, redirect = 1'b0, ill_instr = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, instruction, instr_pc;
  logic        req2, valid2, halted2;
  logic [31:0] addr2, instr2, ipc2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // memory returns an address-tagged word so each delivered instruction is identifiable
  assign imem_rdata = imem_addr ^ K;

  instr_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .ill_instr(ill_instr), .instruction(instruction),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_hi (
    .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .ill_instr(ill_instr), .instruction(instr2),
    .instr_pc(ipc2), .instr_valid(valid2), .halted(halted2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic ack);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; ill_instr = 1'b0; imem_ack = ack;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    cyc();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instruction, NOP);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // 1: streaming, one instruction per cycle
    do_reset(1'b1);
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", {31'd0, instr_valid}, 32'd0);
    cyc();
    chk("t1_addr4", imem_addr, 32'h4);
    chk("t1_ipc0", instr_pc, 32'h0);
    chk("t1_instr0", instruction, 32'h0 ^ K);
    chk("t1_v0", {31'd0, instr_valid}, 32'd1);
    cyc();
    chk("t1_addr8", imem_addr, 32'h8);
    chk("t1_ipc4", instr_pc, 32'h4);
    cyc();
    chk("t1_ipc8", instr_pc, 32'h8);
    chk("t1_addrc", imem_addr, 32'hC);

    // 2: three-cycle stall fills the skid
    stall = 1'b1;
    cyc();
    chk("t2_req_s1", {31'd0, imem_req}, 32'd0);
    chk("t2_hold1", instr_pc, 32'h8);
    cyc();
    chk("t2_req_s2", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("t2_req_s3", {31'd0, imem_req}, 32'd0);
    chk("t2_hold3", instr_pc, 32'h8);
    chk("t2_hold3v", {31'd0, instr_valid}, 32'd1);
    stall = 1'b0;
    cyc();
    chk("t2_skid_ipc", instr_pc, 32'hC);
    chk("t2_skid_instr", instruction, 32'hC ^ K);
    chk("t2_req_back", {31'd0, imem_req}, 32'd1);
    chk("t2_addr10", imem_addr, 32'h10);
    cyc();
    chk("t2_ipc10", instr_pc, 32'h10);

    // 3: redirect while a request waits for its ack
    do_reset(1'b1);
    cyc(); cyc();
    chk("t3_addr8", imem_addr, 32'h8);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    chk("t3_drain_addr", imem_addr, 32'h8);
    chk("t3_drain_req", {31'd0, imem_req}, 32'd1);
    chk("t3_drain_v", {31'd0, instr_valid}, 32'd0);
    chk("t3_drain_nop", instruction, NOP);
    cyc();
    chk("t3_wait2_addr", imem_addr, 32'h8);
    imem_ack = 1'b1;
    cyc();
    chk("t3_drop_v", {31'd0, instr_valid}, 32'd0);
    chk("t3_new_addr", imem_addr, 32'h100);
    chk("t3_new_req", {31'd0, imem_req}, 32'd1);
    cyc();
    chk("t3_ipc100", instr_pc, 32'h100);
    chk("t3_v100", {31'd0, instr_valid}, 32'd1);

    // 4: illegal instruction halts, pending req drained
    ill_instr = 1'b1; imem_ack = 1'b0;
    cyc();
    ill_instr = 1'b0;
    chk("t4_halted", {31'd0, halted}, 32'd1);
    chk("t4_v", {31'd0, instr_valid}, 32'd0);
    chk("t4_nop", instruction, NOP);
    chk("t4_pend_req", {31'd0, imem_req}, 32'd1);
    chk("t4_pend_addr", imem_addr, 32'h104);
    imem_ack = 1'b1;
    cyc();
    chk("t4_req_off", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("t4_sticky", {31'd0, halted}, 32'd1);
    chk("t4_sticky_req", {31'd0, imem_req}, 32'd0);
    chk("t4_sticky_v", {31'd0, instr_valid}, 32'd0);
    do_reset(1'b1);
    chk("t4_unhalt", {31'd0, halted}, 32'd0);

    // 5: misaligned redirect halts; redirect beats ill_instr
    do_reset(1'b0);
    redirect = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect = 1'b0;
    chk("t5_halted", {31'd0, halted}, 32'd1);
    chk("t5_addr_old", imem_addr, 32'h0);
    imem_ack = 1'b1;
    cyc();
    chk("t5_req_off", {31'd0, imem_req}, 32'd0);
    chk("t5_addr_pc", imem_addr, 32'h0);
    do_reset(1'b1);
    cyc();
    chk("t5_v0", {31'd0, instr_valid}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h40; ill_instr = 1'b1;
    cyc();
    redirect = 1'b0; ill_instr = 1'b0;
    chk("t5_no_halt", {31'd0, halted}, 32'd0);
    chk("t5_v_clr", {31'd0, instr_valid}, 32'd0);
    chk("t5_addr40", imem_addr, 32'h40);
    cyc();
    chk("t5_ipc40", instr_pc, 32'h40);

    // 6: PC wrap on the high-reset instance, then async reset mid-DRAIN
    do_reset(1'b1);
    chk("t6_a0", addr2, 32'hFFFF_FFF8);
    cyc();
    chk("t6_a1", addr2, 32'hFFFF_FFFC);
    chk("t6_ipc0", ipc2, 32'hFFFF_FFF8);
    cyc();
    chk("t6_a2", addr2, 32'h0000_0000);
    chk("t6_ipc1", ipc2, 32'hFFFF_FFFC);
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    chk("t6_drain_req", {31'd0, imem_req}, 32'd1);
    chk("t6_drain_addr", imem_addr, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
    chk("t6_rst_addr", imem_addr, 32'h0);
    chk("t6_rst_v", {31'd0, instr_valid}, 32'd0);
    chk("t6_rst_instr", instruction, NOP);
    chk("t6_rst_hi_addr", addr2, 32'hFFFF_FFF8);
    chk("t6_rst_hi_ipc", ipc2, 32'hFFFF_FFF8);
    chk("t6_rst_hi_req", {31'd0, req2}, 32'd0);
    chk("t6_rst_halted", {31'd0, halted2}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_after_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
